// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, load-channel indices and debounce default for the ALU front end
package alu_pkg;
  localparam int NB_DATA_DEF         = 8;
  localparam int N_BTN_DEF           = 3;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;

  localparam int LD_A  = 0;
  localparam int LD_B  = 1;
  localparam int LD_OP = 2;
endpackage

// File: rtl/btn_load_conditioner_if.sv
// rtl/btn_load_conditioner_if.sv - button/switch inputs and load-strobe outputs of the conditioner
interface btn_load_conditioner_if #(
  parameter int NB_DATA = 8,
  parameter int N_BTN   = 3
);
  logic [N_BTN-1:0]   i_btn;
  logic [NB_DATA-1:0] i_switches;
  logic [N_BTN-1:0]   o_load;
  logic [NB_DATA-1:0] o_data;
  logic [N_BTN-1:0]   o_btn_level;

  modport master (
    output i_btn, i_switches,
    input  o_load, o_data, o_btn_level
  );

  modport slave (
    input  i_btn, i_switches,
    output o_load, o_data, o_btn_level
  );
endinterface

// File: rtl/btn_load_conditioner_debounce.sv
// rtl/btn_load_conditioner_debounce.sv - one button channel: 2-flop sync, debounce counter, stable level, press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NB_CNT          = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_stable,
  output logic o_rise
);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEBOUNCE_CYCLES - 1);

  logic              sync1;
  logic              btn_s;
  logic              stable;
  logic [NB_CNT-1:0] cnt;
  logic              accept;

  // accept is high on the edge that commits btn_s into stable
  assign accept   = (btn_s != stable) && (cnt == CNT_LAST);
  assign o_rise   = accept & btn_s;
  assign o_stable = stable;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1  <= 1'b0;
      btn_s  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= i_btn;
      btn_s <= sync1;
      if (btn_s == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= btn_s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + NB_CNT'(1);
      end
    end
  end
endmodule

// File: rtl/btn_load_conditioner.sv
// rtl/btn_load_conditioner.sv - debounced buttons to one-hot load strobes plus switch word; SWITCH_SYNC_EN selects synced snapshot data
module btn_load_conditioner
  import alu_pkg::*;
#(
  parameter int NB_DATA         = NB_DATA_DEF,
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic                    i_clk,
  input logic                    i_reset,
  btn_load_conditioner_if.slave  bus
);
  localparam int NB_CNT = $clog2(DEBOUNCE_CYCLES + 1);

  logic [N_BTN-1:0]   rise;
  logic [N_BTN-1:0]   stable;
  logic [N_BTN-1:0]   load_nxt;
  logic [N_BTN-1:0]   load_q;
  logic [NB_DATA-1:0] data_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .NB_CNT          (NB_CNT)
    ) u_debounce (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_btn    (bus.i_btn[i]),
      .o_stable (stable[i]),
      .o_rise   (rise[i])
    );
  end

  // Scan high-to-low so the lowest-index press is the one left standing
  always_comb begin
    load_nxt = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (rise[i]) begin
        load_nxt = N_BTN'(1) << i;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) load_q <= '0;
    else         load_q <= load_nxt;
  end

`ifdef SWITCH_SYNC_EN
  logic [NB_DATA-1:0] sw_s1;
  logic [NB_DATA-1:0] sw_s2;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      data_q <= '0;
    end else begin
      sw_s1 <= bus.i_switches;
      sw_s2 <= sw_s1;
      if (|rise) data_q <= sw_s2;
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (i_reset) data_q <= '0;
    else         data_q <= bus.i_switches;
  end
`endif

  assign bus.o_load      = load_q;
  assign bus.o_data      = data_q;
  assign bus.o_btn_level = stable;
endmodule
